// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch control: run/pause/done FSM, 1 s prescaler and BCD live/lap time registers.
// Button pulses act on the next clk edge; digits and tick are combinational from registers.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       lap_shown,
  output logic       overflow,
  output logic       tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
  } bcd_t;

  localparam bcd_t TIME_ZERO = '0;
  localparam bcd_t TIME_MAX  = '{mt: 4'd5, mo: 4'd9, st: 4'd5, so: 4'd9};

  state_t         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  bcd_t           live_q, live_d;
  bcd_t           lap_q, lap_d;
  logic           lap_shown_q, lap_shown_d;
  logic           running_q, running_d;
  logic           overflow_q, overflow_d;
  logic           tick_w;

  // Ripple carry through the four digits; never called at 59:59.
  function automatic bcd_t bcd_inc(input bcd_t t);
    bcd_t r;
    r = t;
    if (t.so != 4'd9) begin
      r.so = t.so + 4'd1;
    end else begin
      r.so = 4'd0;
      if (t.st != 4'd5) begin
        r.st = t.st + 4'd1;
      end else begin
        r.st = 4'd0;
        if (t.mo != 4'd9) begin
          r.mo = t.mo + 4'd1;
        end else begin
          r.mo = 4'd0;
          r.mt = t.mt + 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign tick_w = (state_q == RUN) && (presc_q == PRESC_MAX);

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    live_d      = live_q;
    lap_d       = lap_q;
    lap_shown_d = lap_shown_q;
    case (state_q)
      IDLE: begin
        if (btn_ss) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      RUN: begin
        // Lap always sees the pre-increment live value.
        if (btn_lap) begin
          if (!lap_shown_q) begin
            lap_d       = live_q;
            lap_shown_d = 1'b1;
          end else begin
            lap_shown_d = 1'b0;
          end
        end
        if (tick_w) begin
          presc_d = '0;
          if (live_q == TIME_MAX) begin
            state_d = DONE;
          end else begin
            live_d = bcd_inc(live_q);
            if (btn_ss) state_d = PAUSE;
          end
        end else if (btn_ss) begin
          state_d = PAUSE;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      PAUSE: begin
        if (btn_clr) begin
          state_d     = IDLE;
          presc_d     = '0;
          live_d      = TIME_ZERO;
          lap_d       = TIME_ZERO;
          lap_shown_d = 1'b0;
        end else begin
          if (btn_lap) lap_shown_d = 1'b0;
          if (btn_ss)  state_d = RUN;
        end
      end
      DONE: begin
        if (btn_clr) begin
          state_d     = IDLE;
          presc_d     = '0;
          live_d      = TIME_ZERO;
          lap_d       = TIME_ZERO;
          lap_shown_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d  = (state_d == RUN);
    overflow_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      live_q      <= TIME_ZERO;
      lap_q       <= TIME_ZERO;
      lap_shown_q <= 1'b0;
      running_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      live_q      <= live_d;
      lap_q       <= lap_d;
      lap_shown_q <= lap_shown_d;
      running_q   <= running_d;
      overflow_q  <= overflow_d;
    end
  end

  bcd_t disp;
  assign disp      = lap_shown_q ? lap_q : live_q;
  assign min_tens  = disp.mt;
  assign min_ones  = disp.mo;
  assign sec_tens  = disp.st;
  assign sec_ones  = disp.so;
  assign running   = running_q;
  assign lap_shown = lap_shown_q;
  assign overflow  = overflow_q;
  assign tick      = tick_w;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4: directed scenarios plus random buttons
// checked against a seconds-count reference model.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic running, lap_shown, overflow, tick;

  int checks = 0;
  int failures = 0;

  // Reference model: time kept as whole seconds, phase as cycles into the second.
  int m_mode, m_pre, m_live, m_lap;
  bit m_shown;

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .lap_shown(lap_shown), .overflow(overflow), .tick(tick)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] dut_disp();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  function automatic logic [19:0] dut_pack();
    return {min_tens, min_ones, sec_tens, sec_ones, running, lap_shown, overflow, tick};
  endfunction

  function automatic logic [19:0] model_pack();
    int d;
    d = m_shown ? m_lap : m_live;
    return {to_bcd(d), m_mode == M_RUN, m_shown, m_mode == M_DONE,
            (m_mode == M_RUN) && (m_pre == TD - 1)};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_pre = 0; m_live = 0; m_lap = 0; m_shown = 0;
  endtask

  task automatic model_edge(input bit ss, input bit lap, input bit clr);
    bit tk;
    tk = (m_mode == M_RUN) && (m_pre == TD - 1);
    case (m_mode)
      M_IDLE: if (ss) begin m_mode = M_RUN; m_pre = 0; end
      M_RUN: begin
        if (lap) begin
          if (!m_shown) begin m_lap = m_live; m_shown = 1; end
          else m_shown = 0;
        end
        if (tk) begin
          m_pre = 0;
          if (m_live == 3599) m_mode = M_DONE;
          else begin
            m_live = m_live + 1;
            if (ss) m_mode = M_PAUSE;
          end
        end else if (ss) m_mode = M_PAUSE;
        else m_pre = m_pre + 1;
      end
      M_PAUSE: begin
        if (clr) model_reset();
        else begin
          if (lap) m_shown = 0;
          if (ss) m_mode = M_RUN;
        end
      end
      default: if (clr) model_reset();
    endcase
  endtask

  // One clock cycle with the given buttons; returns at the following falling edge.
  task automatic step(input bit ss, input bit lap, input bit clr);
    btn_ss = ss; btn_lap = lap; btn_clr = clr;
    @(posedge clk);
    model_edge(ss, lap, clr);
    #1;
    btn_ss = 0; btn_lap = 0; btn_clr = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (dut_pack() !== 20'h0) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", dut_pack(), 20'h0);
    end
    @(negedge clk);
    reset = 0;
    model_reset();
    step(0, 1, 0);
    step(0, 1, 1);
    checks++;
    if (dut_pack() !== 20'h0) begin
      failures++; $display("FAIL idle_ignores_lap_clr got=%h exp=%h", dut_pack(), 20'h0);
    end
  endtask

  task automatic test_count();
    int nticks, first;
    nticks = 0; first = -1;
    step(1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0);
      if (tick === 1'b1) begin
        nticks++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (first != TD - 2) begin
      failures++; $display("FAIL first_tick_cycle got=%0d exp=%0d", first, TD - 2);
    end
    checks++;
    if (nticks != 10) begin
      failures++; $display("FAIL tick_count got=%0d exp=10", nticks);
    end
    checks++;
    if (dut_disp() !== 16'h0010 || running !== 1'b1) begin
      failures++; $display("FAIL count_40 got=%h run=%b exp=0010 run=1", dut_disp(), running);
    end
    step(1, 0, 0);
    step(0, 0, 1);
  endtask

  task automatic test_overflow();
    step(1, 0, 0);
    for (int i = 0; i < 59 * TD; i++) step(0, 0, 0);
    checks++;
    if (dut_disp() !== 16'h0059) begin
      failures++; $display("FAIL at_00_59 got=%h exp=0059", dut_disp());
    end
    for (int i = 0; i < TD; i++) step(0, 0, 0);
    checks++;
    if (dut_disp() !== 16'h0100) begin
      failures++; $display("FAIL min_carry got=%h exp=0100", dut_disp());
    end
    for (int i = 0; i < (3599 - 60) * TD; i++) step(0, 0, 0);
    checks++;
    if (dut_disp() !== 16'h5959 || running !== 1'b1 || overflow !== 1'b0) begin
      failures++; $display("FAIL at_59_59 got=%h run=%b ovf=%b exp=5959 1 0", dut_disp(), running, overflow);
    end
    for (int i = 0; i < TD; i++) step(0, 0, 0);
    checks++;
    if (dut_disp() !== 16'h5959 || running !== 1'b0 || overflow !== 1'b1) begin
      failures++; $display("FAIL overflow got=%h run=%b ovf=%b exp=5959 0 1", dut_disp(), running, overflow);
    end
    step(1, 1, 0);
    step(0, 0, 0);
    checks++;
    if (dut_pack() !== {16'h5959, 4'b0010}) begin
      failures++; $display("FAIL done_ignores_ss got=%h exp=%h", dut_pack(), {16'h5959, 4'b0010});
    end
    step(0, 0, 1);
    checks++;
    if (dut_pack() !== 20'h0) begin
      failures++; $display("FAIL done_clear got=%h exp=%h", dut_pack(), 20'h0);
    end
  endtask

  task automatic test_lap();
    step(1, 0, 0);
    for (int i = 0; i < 7 * TD; i++) step(0, 0, 0);
    step(0, 1, 0);
    checks++;
    if (dut_disp() !== 16'h0007 || lap_shown !== 1'b1) begin
      failures++; $display("FAIL lap_capture got=%h shown=%b exp=0007 1", dut_disp(), lap_shown);
    end
    for (int i = 0; i < 5 * TD - 1; i++) step(0, 0, 0);
    checks++;
    if (dut_disp() !== 16'h0007 || running !== 1'b1) begin
      failures++; $display("FAIL lap_frozen got=%h run=%b exp=0007 1", dut_disp(), running);
    end
    step(0, 1, 0);
    checks++;
    if (dut_disp() !== 16'h0012 || lap_shown !== 1'b0) begin
      failures++; $display("FAIL lap_release got=%h shown=%b exp=0012 0", dut_disp(), lap_shown);
    end
    step(1, 0, 0);
    step(0, 0, 1);
  endtask

  task automatic test_pause();
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0);
      checks++;
      if (dut_pack() !== {16'h0001, 4'b0000}) begin
        failures++; $display("FAIL paused_hold cyc=%0d got=%h exp=%h", i, dut_pack(), {16'h0001, 4'b0000});
      end
    end
    step(1, 0, 0);
    checks++;
    if (tick !== 1'b0 || running !== 1'b1) begin
      failures++; $display("FAIL resume_edge tick=%b run=%b exp=0 1", tick, running);
    end
    step(0, 0, 0);
    checks++;
    if (tick !== 1'b1 || dut_disp() !== 16'h0001) begin
      failures++; $display("FAIL resume_tick tick=%b got=%h exp=1 0001", tick, dut_disp());
    end
    step(0, 0, 0);
    checks++;
    if (dut_disp() !== 16'h0002) begin
      failures++; $display("FAIL resume_inc got=%h exp=0002", dut_disp());
    end
    step(1, 0, 0);
    step(0, 0, 1);
  endtask

  task automatic test_back_to_back();
    // ss + lap + tick on one edge: increment, capture pre-increment value, pause.
    step(1, 0, 0);
    for (int i = 0; i < TD - 1; i++) step(0, 0, 0);
    step(1, 1, 0);
    checks++;
    if (dut_pack() !== {16'h0000, 4'b0100} || m_live != 1) begin
      failures++; $display("FAIL ss_lap_tick got=%h exp=%h", dut_pack(), {16'h0000, 4'b0100});
    end
    step(0, 1, 0);
    checks++;
    if (dut_pack() !== {16'h0001, 4'b0000}) begin
      failures++; $display("FAIL pause_lap_release got=%h exp=%h", dut_pack(), {16'h0001, 4'b0000});
    end
    step(0, 0, 1);
  endtask

  task automatic test_clear();
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    step(0, 0, 1);
    checks++;
    if (running !== 1'b1 || dut_disp() !== 16'h0002) begin
      failures++; $display("FAIL clr_in_run run=%b got=%h exp=1 0002", running, dut_disp());
    end
    step(1, 0, 0);
    step(1, 1, 1);
    step(0, 0, 0);
    checks++;
    if (dut_pack() !== 20'h0) begin
      failures++; $display("FAIL clr_ss_pause got=%h exp=%h", dut_pack(), 20'h0);
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 0);
    for (int i = 0; i < 207 * TD; i++) step(0, 0, 0);
    checks++;
    if (dut_disp() !== 16'h0327 || running !== 1'b1) begin
      failures++; $display("FAIL at_03_27 got=%h run=%b exp=0327 1", dut_disp(), running);
    end
    #1 reset = 1;
    #1;
    checks++;
    if (dut_pack() !== 20'h0) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", dut_pack(), 20'h0);
    end
    #1 reset = 0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_random();
    bit ss, lap, clr;
    for (int i = 0; i < 4000; i++) begin
      ss  = ($urandom_range(0, 29) == 0);
      lap = ($urandom_range(0, 19) == 0);
      clr = ($urandom_range(0, 59) == 0);
      step(ss, lap, clr);
      checks++;
      if (dut_pack() !== model_pack()) begin
        failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_pack(), model_pack());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count();
    test_overflow();
    test_lap();
    test_pause();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
